// File: rtl/dsp48a1_slice.sv
// DSP48A1-style MAC slice: D+/-B pre-adder, 18x18 unsigned multiplier, X/Z muxes and a 48-bit
// post-adder with carry. Each pipeline stage can be registered, with its own sync reset and enable.
module dsp48a1_slice #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 0,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 0,
  parameter int    CREG        = 0,
  parameter int    DREG        = 0,
  parameter int    MREG        = 0,
  parameter int    PREG        = 0,
  parameter int    CARRYINREG  = 0,
  parameter int    CARRYOUTREG = 0,
  parameter int    OPMODEREG   = 0,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "SYNC"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [17:0] b_sel, a0, b0, a1, b1, d_r, pre;
  logic [47:0] c_r, x_mux, z_mux, p_r;
  logic [7:0]  opm;
  logic [35:0] mult, m_r;
  logic        cin_src, cin, cout_r;
  logic [48:0] result;

  assign b_sel = (B_INPUT == "CASCADE") ? BCIN : B;

  // Each stage: reset beats enable; a disabled stage is a plain wire.
  if (A0REG == 1) begin : g_a0
    always_ff @(posedge CLK) if (RSTA) a0 <= '0; else if (CEA) a0 <= A;
  end else begin : g_a0_w
    assign a0 = A;
  end

  if (B0REG == 1) begin : g_b0
    always_ff @(posedge CLK) if (RSTB) b0 <= '0; else if (CEB) b0 <= b_sel;
  end else begin : g_b0_w
    assign b0 = b_sel;
  end

  if (CREG == 1) begin : g_c
    always_ff @(posedge CLK) if (RSTC) c_r <= '0; else if (CEC) c_r <= C;
  end else begin : g_c_w
    assign c_r = C;
  end

  if (DREG == 1) begin : g_d
    always_ff @(posedge CLK) if (RSTD) d_r <= '0; else if (CED) d_r <= D;
  end else begin : g_d_w
    assign d_r = D;
  end

  if (OPMODEREG == 1) begin : g_opm
    always_ff @(posedge CLK) if (RSTOPMODE) opm <= '0; else if (CEOPMODE) opm <= OPMODE;
  end else begin : g_opm_w
    assign opm = OPMODE;
  end

  assign pre = !opm[4] ? b0 : (opm[6] ? d_r - b0 : d_r + b0);

  if (B1REG == 1) begin : g_b1
    always_ff @(posedge CLK) if (RSTB) b1 <= '0; else if (CEB) b1 <= pre;
  end else begin : g_b1_w
    assign b1 = pre;
  end

  if (A1REG == 1) begin : g_a1
    always_ff @(posedge CLK) if (RSTA) a1 <= '0; else if (CEA) a1 <= a0;
  end else begin : g_a1_w
    assign a1 = a0;
  end

  assign mult = 36'(b1) * 36'(a1);

  if (MREG == 1) begin : g_m
    always_ff @(posedge CLK) if (RSTM) m_r <= '0; else if (CEM) m_r <= mult;
  end else begin : g_m_w
    assign m_r = mult;
  end

  assign cin_src = (CARRYINSEL == "CARRYIN") ? CARRYIN : opm[5];

  if (CARRYINREG == 1) begin : g_cin
    always_ff @(posedge CLK) if (RSTCARRYIN) cin <= 1'b0; else if (CECARRYIN) cin <= cin_src;
  end else begin : g_cin_w
    assign cin = cin_src;
  end

  always_comb begin
    x_mux = '0;
    case (opm[1:0])
      2'd1:    x_mux = {12'd0, m_r};
      2'd2:    x_mux = p_r;
      2'd3:    x_mux = {d_r[11:0], a1, b1};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (opm[3:2])
      2'd1:    z_mux = PCIN;
      2'd2:    z_mux = p_r;
      2'd3:    z_mux = c_r;
      default: z_mux = '0;
    endcase
  end

  // Bit 48 is carry on add and borrow on subtract.
  assign result = opm[7] ? {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin})
                         : {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};

  if (PREG == 1) begin : g_p
    always_ff @(posedge CLK) if (RSTP) p_r <= '0; else if (CEP) p_r <= result[47:0];
  end else begin : g_p_w
    assign p_r = result[47:0];
  end

  if (CARRYOUTREG == 1) begin : g_cout
    always_ff @(posedge CLK) if (RSTCARRYIN) cout_r <= 1'b0; else if (CECARRYIN) cout_r <= result[48];
  end else begin : g_cout_w
    assign cout_r = result[48];
  end

  assign BCOUT     = b1;
  assign M         = m_r;
  assign P         = p_r;
  assign PCOUT     = p_r;
  assign CARRYOUT  = cout_r;
  assign CARRYOUTF = cout_r;

  // Controls and inputs that go unused under some parameter settings.
  logic unused_ok;
  assign unused_ok = &{1'b0, CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEOPMODE,
                       RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTCARRYIN, RSTOPMODE,
                       B, BCIN, CARRYIN, opm, CLK, RSTTYPE == "SYNC"};

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed bench: a combinational (all-bypass) slice and a fully pipelined slice on shared inputs.
module tb_dsp48a1_slice;

  logic        clk = 1'b0;
  logic        rst_all = 1'b0;
  logic        cea = 1'b1, ceb = 1'b1, cem = 1'b1, cep = 1'b1;
  logic        cec = 1'b1, ced = 1'b1, cecin = 1'b1, ceopm = 1'b1;
  logic [17:0] a = '0, b = '0, bcin = '0, d = '0;
  logic [47:0] c = '0, pcin = '0;
  logic        carryin = 1'b0;
  logic [7:0]  opmode = '0;

  logic [17:0] bcout_c, bcout_p;
  logic [35:0] m_c, m_p;
  logic [47:0] p_c, p_p, pcout_c, pcout_p;
  logic        co_c, co_p, cof_c, cof_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp48a1_slice u_comb (
    .CLK(clk), .RSTA(rst_all), .RSTB(rst_all), .RSTM(rst_all), .RSTP(rst_all),
    .RSTC(rst_all), .RSTD(rst_all), .RSTCARRYIN(rst_all), .RSTOPMODE(rst_all),
    .CEA(cea), .CEB(ceb), .CEM(cem), .CEP(cep), .CEC(cec), .CED(ced),
    .CECARRYIN(cecin), .CEOPMODE(ceopm),
    .A(a), .B(b), .BCIN(bcin), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode),
    .BCOUT(bcout_c), .M(m_c), .P(p_c), .PCOUT(pcout_c), .CARRYOUT(co_c), .CARRYOUTF(cof_c)
  );

  dsp48a1_slice #(
    .A0REG(1), .A1REG(1), .B0REG(1), .B1REG(1), .CREG(1), .DREG(1), .MREG(1), .PREG(1),
    .CARRYINREG(1), .CARRYOUTREG(1), .OPMODEREG(1), .CARRYINSEL("CARRYIN")
  ) u_pipe (
    .CLK(clk), .RSTA(rst_all), .RSTB(rst_all), .RSTM(rst_all), .RSTP(rst_all),
    .RSTC(rst_all), .RSTD(rst_all), .RSTCARRYIN(rst_all), .RSTOPMODE(rst_all),
    .CEA(cea), .CEB(ceb), .CEM(cem), .CEP(cep), .CEC(cec), .CED(ced),
    .CECARRYIN(cecin), .CEOPMODE(ceopm),
    .A(a), .B(b), .BCIN(bcin), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin), .OPMODE(opmode),
    .BCOUT(bcout_p), .M(m_p), .P(p_p), .PCOUT(pcout_p), .CARRYOUT(co_p), .CARRYOUTF(cof_p)
  );

  typedef struct {
    logic [7:0]  op;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    logic        ci;
    logic [17:0] e_bc;
    logic [35:0] e_m;
    logic [47:0] e_p;
    logic        e_co;
  } vec_t;

  task automatic test_comb_vectors();
    vec_t v[4];
    v[0] = '{8'b10100111, 18'd0, 18'd4,  18'd0,  48'd0, 48'd10,  1'b0, 18'd4,  36'd0,  48'd5,   1'b0};
    v[1] = '{8'b00011101, 18'd3, 18'd10, 18'd9,  48'd3, 48'd0,   1'b1, 18'd19, 36'd57, 48'd60,  1'b0};
    v[2] = '{8'b11010101, 18'd6, 18'd10, 18'd20, 48'd0, 48'd600, 1'b0, 18'd10, 36'd60, 48'd540, 1'b0};
    v[3] = '{8'b11010000, 18'd6, 18'd10, 18'd20, 48'd0, 48'd600, 1'b0, 18'd10, 36'd60, 48'd0,   1'b0};
    for (int i = 0; i < 4; i++) begin
      opmode = v[i].op; a = v[i].a; b = v[i].b; d = v[i].d;
      c = v[i].c; pcin = v[i].pcin; carryin = v[i].ci;
      #1;
      checks += 6;
      if (bcout_c !== v[i].e_bc) begin failures++; $display("FAIL comb_bcout[%0d] got=%0d exp=%0d", i, bcout_c, v[i].e_bc); end
      if (m_c !== v[i].e_m)      begin failures++; $display("FAIL comb_m[%0d] got=%0d exp=%0d", i, m_c, v[i].e_m); end
      if (p_c !== v[i].e_p)      begin failures++; $display("FAIL comb_p[%0d] got=%0d exp=%0d", i, p_c, v[i].e_p); end
      if (pcout_c !== v[i].e_p)  begin failures++; $display("FAIL comb_pcout[%0d] got=%0d exp=%0d", i, pcout_c, v[i].e_p); end
      if (co_c !== v[i].e_co)    begin failures++; $display("FAIL comb_carryout[%0d] got=%0b exp=%0b", i, co_c, v[i].e_co); end
      if (cof_c !== v[i].e_co)   begin failures++; $display("FAIL comb_carryoutf[%0d] got=%0b exp=%0b", i, cof_c, v[i].e_co); end
    end
  endtask

  task automatic test_comb_boundary();
    vec_t v[4];
    v[0] = '{8'b00111111, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'd0, 48'd0, 1'b0,
             18'd262142, 36'd68718690306, 48'hFFFF_FFFF_FFFF, 1'b0};
    v[1] = '{8'b10100111, 18'd0, 18'd4, 18'd0, 48'd0, 48'd3, 1'b0,
             18'd4, 36'd0, 48'hFFFF_FFFF_FFFE, 1'b1};
    v[2] = '{8'b00001111, 18'd0, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0,
             18'd1, 36'd0, 48'd0, 1'b1};
    v[3] = '{8'b01010001, 18'd2, 18'd1, 18'd0, 48'd0, 48'd0, 1'b0,
             18'd262143, 36'd524286, 48'd524286, 1'b0};
    for (int i = 0; i < 4; i++) begin
      opmode = v[i].op; a = v[i].a; b = v[i].b; d = v[i].d;
      c = v[i].c; pcin = v[i].pcin; carryin = v[i].ci;
      #1;
      checks += 5;
      if (bcout_c !== v[i].e_bc) begin failures++; $display("FAIL bound_bcout[%0d] got=%0d exp=%0d", i, bcout_c, v[i].e_bc); end
      if (m_c !== v[i].e_m)      begin failures++; $display("FAIL bound_m[%0d] got=%0d exp=%0d", i, m_c, v[i].e_m); end
      if (p_c !== v[i].e_p)      begin failures++; $display("FAIL bound_p[%0d] got=%0h exp=%0h", i, p_c, v[i].e_p); end
      if (co_c !== v[i].e_co)    begin failures++; $display("FAIL bound_carryout[%0d] got=%0b exp=%0b", i, co_c, v[i].e_co); end
      if (cof_c !== v[i].e_co)   begin failures++; $display("FAIL bound_carryoutf[%0d] got=%0b exp=%0b", i, cof_c, v[i].e_co); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_all = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (p_p !== 48'd0)     begin failures++; $display("FAIL reset_p got=%0d exp=0", p_p); end
    if (pcout_p !== 48'd0) begin failures++; $display("FAIL reset_pcout got=%0d exp=0", pcout_p); end
    if (m_p !== 36'd0)     begin failures++; $display("FAIL reset_m got=%0d exp=0", m_p); end
    if (bcout_p !== 18'd0) begin failures++; $display("FAIL reset_bcout got=%0d exp=0", bcout_p); end
    if (co_p !== 1'b0 || cof_p !== 1'b0) begin failures++; $display("FAIL reset_carryout got=%0b/%0b exp=0", co_p, cof_p); end
    rst_all = 1'b0;
  endtask

  // P = C + M with carry-in taken from the (zero) CARRYIN port.
  task automatic test_pipeline();
    opmode = 8'b00111101; a = 18'd3; b = 18'd2; d = 18'd0; c = 48'd4; pcin = '0; carryin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (p_p !== 48'd4)     begin failures++; $display("FAIL pipe_p_edge3 got=%0d exp=4", p_p); end
    if (m_p !== 36'd6)     begin failures++; $display("FAIL pipe_m_edge3 got=%0d exp=6", m_p); end
    if (bcout_p !== 18'd2) begin failures++; $display("FAIL pipe_bcout_edge3 got=%0d exp=2", bcout_p); end
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (p_p !== 48'd10)     begin failures++; $display("FAIL pipe_p_full got=%0d exp=10", p_p); end
    if (pcout_p !== 48'd10) begin failures++; $display("FAIL pipe_pcout_full got=%0d exp=10", pcout_p); end
  endtask

  task automatic test_midop_reset();
    rst_all = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (p_p !== 48'd0)     begin failures++; $display("FAIL midrst_p got=%0d exp=0", p_p); end
    if (m_p !== 36'd0)     begin failures++; $display("FAIL midrst_m got=%0d exp=0", m_p); end
    if (bcout_p !== 18'd0) begin failures++; $display("FAIL midrst_bcout got=%0d exp=0", bcout_p); end
    if (co_p !== 1'b0)     begin failures++; $display("FAIL midrst_carryout got=%0b exp=0", co_p); end
    rst_all = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (p_p !== 48'd10) begin failures++; $display("FAIL midrst_recover_p got=%0d exp=10", p_p); end
  endtask

  task automatic test_ce_hold();
    cep = 1'b0; c = 48'd100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (p_p !== 48'd10) begin failures++; $display("FAIL cep_hold_p got=%0d exp=10", p_p); end
    if (m_p !== 36'd6)  begin failures++; $display("FAIL cep_hold_m got=%0d exp=6", m_p); end
    cep = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (p_p !== 48'd106) begin failures++; $display("FAIL cep_resume_p got=%0d exp=106", p_p); end
  endtask

  initial begin
    test_comb_vectors();
    test_comb_boundary();
    test_reset();
    test_pipeline();
    test_midop_reset();
    test_ce_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
